// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: FSM states, inverse S-box and GF(2^8) helpers.
// State vectors are [0:127] with byte i at bits [8i:8i+7] and byte row*4+col.
package aes_pkg;

   typedef enum logic [2:0] {IDLE, ARK, ROUND, FINAL, DONE} fsm_t;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] gf_mul2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul9(input logic [7:0] a);
      return gf_mul2(gf_mul2(gf_mul2(a))) ^ a;
   endfunction

   function automatic logic [7:0] gf_mulb(input logic [7:0] a);
      return gf_mul2(gf_mul2(gf_mul2(a))) ^ gf_mul2(a) ^ a;
   endfunction

   function automatic logic [7:0] gf_muld(input logic [7:0] a);
      return gf_mul2(gf_mul2(gf_mul2(a))) ^ gf_mul2(gf_mul2(a)) ^ a;
   endfunction

   function automatic logic [7:0] gf_mule(input logic [7:0] a);
      return gf_mul2(gf_mul2(gf_mul2(a))) ^ gf_mul2(gf_mul2(a)) ^ gf_mul2(a);
   endfunction

   function automatic int bidx(input int row, input int col);
      return row * 4 + col;
   endfunction

endpackage

// File: rtl/ShiftRowsInverse.sv
// InvShiftRows: row r of the row-major state rotates right by r byte positions.
module ShiftRowsInverse
   import aes_pkg::*;
(
   input  logic [0:127] din,
   output logic [0:127] dout
);
   always_comb begin
      dout = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            dout[8*bidx(r, c) +: 8] = din[8*bidx(r, (c - r + 4) % 4) +: 8];
   end
endmodule

// File: rtl/aes_inv_round.sv
// One combinational inverse-cipher round; the final round skips InvMixColumns.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [0:127] state,
   input  logic [0:127] key,
   input  logic         last_round,
   output logic [0:127] next_state
);
   logic [0:127] sr, sb, ak, mc;
   logic [7:0]   s0, s1, s2, s3;

   ShiftRowsInverse u_isr (.din(state), .dout(sr));

   always_comb begin
      sb = '0;
      mc = '0;
      s0 = '0;
      s1 = '0;
      s2 = '0;
      s3 = '0;
      for (int i = 0; i < 16; i++) sb[8*i +: 8] = INV_SBOX[sr[8*i +: 8]];
      ak = sb ^ key;
      // a column is bytes {c, 4+c, 8+c, 12+c} in this layout
      for (int c = 0; c < 4; c++) begin
         s0 = ak[8*bidx(0, c) +: 8];
         s1 = ak[8*bidx(1, c) +: 8];
         s2 = ak[8*bidx(2, c) +: 8];
         s3 = ak[8*bidx(3, c) +: 8];
         mc[8*bidx(0, c) +: 8] = gf_mule(s0) ^ gf_mulb(s1) ^ gf_muld(s2) ^ gf_mul9(s3);
         mc[8*bidx(1, c) +: 8] = gf_mul9(s0) ^ gf_mule(s1) ^ gf_mulb(s2) ^ gf_muld(s3);
         mc[8*bidx(2, c) +: 8] = gf_muld(s0) ^ gf_mul9(s1) ^ gf_mule(s2) ^ gf_mulb(s3);
         mc[8*bidx(3, c) +: 8] = gf_mulb(s0) ^ gf_muld(s1) ^ gf_mul9(s2) ^ gf_mule(s3);
      end
      next_state = last_round ? ak : mc;
   end
endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched by index
// from an external schedule store with same-cycle return.
module aes_inv_cipher_ctrl
   import aes_pkg::*;
#(
   parameter int NR     = 10,
   parameter int KIDX_W = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [0:127]      in_data,
   output logic [KIDX_W-1:0] key_idx,
   input  logic [0:127]      round_key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:127]      out_data,
   output logic              busy
);
   localparam logic [KIDX_W-1:0] NR_K  = KIDX_W'(NR);
   localparam logic [KIDX_W-1:0] NR_K1 = KIDX_W'(NR - 1);
   localparam logic [KIDX_W-1:0] ONE_K = KIDX_W'(1);

   fsm_t              st;
   logic [0:127]      state_q, nxt;
   logic [KIDX_W-1:0] rnd;
   logic              last_round;

   assign last_round = (st == FINAL);

   aes_inv_round u_round (
      .state      (state_q),
      .key        (round_key),
      .last_round (last_round),
      .next_state (nxt)
   );

   always_comb begin
      key_idx = '0;
      case (st)
         IDLE:       key_idx = NR_K;
         ARK, ROUND: key_idx = rnd;
         default:    key_idx = '0;
      endcase
   end

   // handshake flags are registered alongside the state transitions
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st        <= IDLE;
         state_q   <= '0;
         out_data  <= '0;
         rnd       <= NR_K;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (st)
            IDLE: if (in_valid) begin
               state_q  <= in_data;
               rnd      <= NR_K;
               st       <= ARK;
               in_ready <= 1'b0;
               busy     <= 1'b1;
            end
            ARK: begin
               state_q <= state_q ^ round_key;
               rnd     <= NR_K1;
               st      <= ROUND;
            end
            ROUND: begin
               state_q <= nxt;
               rnd     <= rnd - ONE_K;
               if (rnd == ONE_K) st <= FINAL;
            end
            FINAL: begin
               state_q   <= nxt;
               out_data  <= nxt;
               out_valid <= 1'b1;
               st        <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               st        <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl: FIPS-197 vectors, key-index trace, stall,
// back-to-back blocks, mid-block reset, and an NR=14 instance.
module tb_aes_inv_cipher_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [0:127] in_data, round_key, out_data;
   logic [3:0]   key_idx;
   logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
   logic [0:127] in_data_b, round_key_b, out_data_b;
   logic [3:0]   key_idx_b;

   logic [0:127] rk10 [16];
   logic [0:127] rk14 [16];
   int passed = 0;
   int total  = 0;

   aes_inv_cipher_ctrl #(.NR(10), .KIDX_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .key_idx(key_idx), .round_key(round_key), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy));

   aes_inv_cipher_ctrl #(.NR(14), .KIDX_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .key_idx(key_idx_b), .round_key(round_key_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_data(out_data_b), .busy(busy_b));

   assign round_key   = rk10[key_idx];
   assign round_key_b = rk14[key_idx_b];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      total++;
      assert (got === want) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, got, want);
   endtask

   // ---- independent forward-AES reference (row-major layout, byte r*4+c) ----
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq, inv, s, t;
      sq  = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      s = inv;
      t = inv;
      for (int k = 0; k < 4; k++) begin
         t = {t[6:0], t[7]};
         s = s ^ t;
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [0:127] transp(input logic [0:127] x);
      logic [0:127] y;
      y = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            y[8*(r*4+c) +: 8] = x[8*(c*4+r) +: 8];
      return y;
   endfunction

   task automatic expand(input logic [0:255] key, input int nk, input int nr, input bit big);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end else if (nk > 6 && i % nk == 4) t = subw(t);
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) begin
         if (big) rk14[r] = transp({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
         else     rk10[r] = transp({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
      end
   endtask

   function automatic logic [0:127] enc10(input logic [0:127] pt);
      logic [0:127] s, t, u;
      logic [7:0]   a0, a1, a2, a3;
      s = pt ^ rk10[0];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) t[8*i +: 8] = sbox(s[8*i +: 8]);
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               u[8*(r*4+c) +: 8] = t[8*(r*4+(c+r)%4) +: 8];
         if (rd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = u[8*c +: 8]; a1 = u[8*(4+c) +: 8]; a2 = u[8*(8+c) +: 8]; a3 = u[8*(12+c) +: 8];
               u[8*c      +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               u[8*(4+c)  +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               u[8*(8+c)  +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               u[8*(12+c) +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         s = u ^ rk10[rd];
      end
      return s;
   endfunction

   // Offers one block and follows it to DONE, checking ready, key index and latency.
   task automatic run_block(input bit big, input logic [0:127] ct, input logic [0:127] pt, input string tag);
      int nr;
      int ek;
      nr = big ? 14 : 10;
      if (big) begin in_data_b = ct; in_valid_b = 1'b1; end
      else     begin in_data   = ct; in_valid   = 1'b1; end
      chk({tag, " rdy c0"}, big ? in_ready_b : in_ready, 1);
      chk({tag, " kidx c0"}, big ? key_idx_b : key_idx, nr);
      for (int c = 1; c <= nr + 2; c++) begin
         tick();
         in_valid   = 1'b0;
         in_valid_b = 1'b0;
         chk($sformatf("%s rdy c%0d", tag, c), big ? in_ready_b : in_ready, 0);
         if (c <= nr + 1) begin
            ek = (c == 1) ? nr : (c == nr + 1) ? 0 : nr + 1 - c;
            chk($sformatf("%s kidx c%0d", tag, c), big ? key_idx_b : key_idx, ek);
         end
         chk($sformatf("%s ovld c%0d", tag, c), big ? out_valid_b : out_valid, (c == nr + 2) ? 1 : 0);
      end
      chk({tag, " data"}, big ? out_data_b : out_data, pt);
   endtask

   logic [0:127] ct1, pt1, ct3, pt3;
   logic [0:127] bpt [3];
   logic [0:127] bct [3];
   int acc_t [3];
   int nacc, nout;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0;
      expand(256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000, 4, 10, 1'b0);
      expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, 1'b1);
      ct1 = transp(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      pt1 = transp(128'h00112233445566778899aabbccddeeff);
      ct3 = transp(128'h8ea2b7ca516745bfeafc49904b496089);
      pt3 = pt1;
      bpt[0] = 128'h000102030405060708090a0b0c0d0e0f;
      bpt[1] = 128'hffeeddccbbaa99887766554433221100;
      bpt[2] = 128'h0123456789abcdeffedcba9876543210;
      for (int i = 0; i < 3; i++) begin bct[i] = enc10(bpt[i]); acc_t[i] = 0; end

      tick(); tick();
      rst_n = 1'b1;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset out_data", out_data, 0);
      chk("reset key_idx", key_idx, 10);

      // FIPS-197 C.1 with key-index trace and 12-cycle latency
      run_block(1'b0, ct1, pt1, "c1");
      chk("c1 busy in done", busy, 1);

      // stall in DONE, new block offered but not taken
      in_data  = ct3;
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk($sformatf("stall ovld %0d", k), out_valid, 1);
         chk($sformatf("stall data %0d", k), out_data, pt1);
         chk($sformatf("stall rdy %0d", k), in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("release rdy", in_ready, 1);
      chk("release ovld", out_valid, 0);
      chk("release busy", busy, 0);

      // back-to-back with out_ready held high
      nacc = 0;
      nout = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         if (nacc < 3) begin in_valid = 1'b1; in_data = bct[nacc]; end
         else in_valid = 1'b0;
         if (out_valid) begin
            chk($sformatf("b2b ovld while rdy %0d", cyc), in_ready, 0);
            if (nout < 3) chk($sformatf("b2b data %0d", nout), out_data, bpt[nout]);
            else chk("b2b extra output", nout, 2);
            nout++;
         end
         if (in_valid && in_ready) begin acc_t[nacc] = cyc; nacc++; end
         tick();
      end
      in_valid = 1'b0;
      chk("b2b accepts", nacc, 3);
      chk("b2b outputs", nout, 3);
      chk("b2b spacing 1", acc_t[1] - acc_t[0], 13);
      chk("b2b spacing 2", acc_t[2] - acc_t[1], 13);

      // reset in the middle of ROUND
      in_data  = ct1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 2; k <= 6; k++) tick();
      chk("mid busy c6", busy, 1);
      chk("mid kidx c6", key_idx, 5);
      rst_n = 1'b0;
      tick();
      chk("rst in_ready", in_ready, 1);
      chk("rst out_valid", out_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst out_data", out_data, 0);
      rst_n     = 1'b1;
      out_ready = 1'b0;
      run_block(1'b0, ct1, pt1, "post");
      out_ready = 1'b1;
      tick();
      chk("post idle", in_ready, 1);

      // AES-256, FIPS-197 C.3
      chk("b reset rdy", in_ready_b, 1);
      run_block(1'b1, ct3, pt3, "c3");
      out_ready_b = 1'b1;
      tick();
      chk("c3 idle", in_ready_b, 1);
      chk("c3 ovld low", out_valid_b, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
